// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the mux4_rr_arbiter slice.
// Build option MUX4_ARB_FIXED_PRIO_EN is consumed in rr_pick2 only.
package mux4_arb_pkg;

    localparam int unsigned DEFAULT_DATA_W = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/downstream handshake bundle for mux4_rr_arbiter.
// slave = arbiter side, master = requesters plus downstream consumer.
interface mux4_rr_arbiter_if
    import mux4_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);

    logic              reqA;
    logic [DATA_W-1:0] inA;
    logic              ackA;
    logic              reqB;
    logic [DATA_W-1:0] inB;
    logic              ackB;
    logic [DATA_W-1:0] out;
    logic              outValid;
    logic              outReady;
    logic              sel;

    modport slave (
        input  reqA, inA, reqB, inB, outReady,
        output ackA, ackB, out, outValid, sel
    );

    modport master (
        output reqA, inA, reqB, inB, outReady,
        input  ackA, ackB, out, outValid, sel
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick2.sv
// Two-way winner selection. Round-robin on lastSel by default;
// MUX4_ARB_FIXED_PRIO_EN makes A always win a tie.
module rr_pick2
    import mux4_arb_pkg::*;
(
    input  logic reqA,
    input  logic reqB,
    input  logic lastSel,
    output logic winner,
    output logic anyReq
);

    always_comb begin
        anyReq = reqA | reqB;
        winner = SEL_A;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        if (!reqA && reqB)
            winner = SEL_B;
`else
        if (reqA && reqB)
            winner = ~lastSel;
        else if (reqB)
            winner = SEL_B;
`endif
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Arbitrates two requesters onto one 2:1 mux into a one-entry output
// register with valid/ready. Build option: MUX4_ARB_FIXED_PRIO_EN (in rr_pick2).
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
)
(
    input  logic              Clk,
    input  logic              Reset,
    mux4_rr_arbiter_if.slave  bus
);

    state_t            state;
    logic              lastSel;
    logic              sel_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] mux_word;
    logic              winner;
    logic              anyReq;
    logic              canLoad;
    logic              ackA;
    logic              ackB;

    rr_pick2 u_pick (
        .reqA    (bus.reqA),
        .reqB    (bus.reqB),
        .lastSel (lastSel),
        .winner  (winner),
        .anyReq  (anyReq)
    );

    always_comb begin
        mux_word = (winner == SEL_B) ? bus.inB : bus.inA;
    end

    // Loading in FULL is allowed when the current word leaves this cycle,
    // which gives one word per cycle under a held outReady.
    always_comb begin
        canLoad = (state == EMPTY) | bus.outReady;
        ackA    = ~Reset & canLoad & anyReq & (winner == SEL_A) & bus.reqA;
        ackB    = ~Reset & canLoad & anyReq & (winner == SEL_B) & bus.reqB;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= EMPTY;
            out_q   <= '0;
            sel_q   <= SEL_A;
            lastSel <= SEL_B;
        end else if (ackA || ackB) begin
            state   <= FULL;
            out_q   <= mux_word;
            sel_q   <= winner;
            lastSel <= winner;
        end else if (state == FULL && bus.outReady) begin
            state   <= EMPTY;
        end
    end

    assign bus.ackA     = ackA;
    assign bus.ackB     = ackB;
    assign bus.out      = out_q;
    assign bus.sel      = sel_q;
    assign bus.outValid = (state == FULL);

endmodule
